// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the parametrised serial-pattern detector.
// Build option: SEQDET_MATCH_COUNT_EN adds the saturating match counter.
package seqdet_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HUNT = 2'd2,
        S_HIT  = 2'd3
    } state_t;

    localparam int MAX_LEN_LIM = 16;
    localparam int MAX_LEN_DEF = 8;
    localparam int LEN_W       = $clog2(MAX_LEN_DEF + 1);

    // Low 'len' bits set; wide enough for the largest legal pattern.
    function automatic logic [MAX_LEN_LIM-1:0] len_mask(input int len);
        logic [MAX_LEN_LIM-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN_LIM; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Config/serial/result bundle of the pattern detector.
// Build option: SEQDET_MATCH_COUNT_EN adds match_cnt.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               x;
    logic               x_valid;
    logic               y;
    logic               busy;
`ifdef SEQDET_MATCH_COUNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output x, x_valid,
        input  y, busy
`ifdef SEQDET_MATCH_COUNT_EN
        , input match_cnt
`endif
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  x, x_valid,
        output y, busy
`ifdef SEQDET_MATCH_COUNT_EN
        , output match_cnt
`endif
    );

endinterface

// File: rtl/seqdet_hist_reg.sv
// Serial history shifter plus saturating fill counter.
// Build option: none (SEQDET_MATCH_COUNT_EN lives in the top).
module seqdet_hist_reg #(
    parameter int W  = 8,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          x_i,
    input  logic [LW-1:0] len_i,
    output logic [W-1:0]  hist_nxt_o,
    output logic          reach_o
);

    // The oldest bit would shift straight out, so only W-1 bits are kept.
    logic [W-2:0]  hist_q, hist_d;
    logic [LW-1:0] fill_q, fill_d;
    logic [LW:0]   fill_inc;

    assign hist_nxt_o = {hist_q, x_i};
    assign fill_inc   = {1'b0, fill_q} + (LW+1)'(1);
    assign reach_o    = fill_inc >= {1'b0, len_i};

    // Clear wins over shift; fill saturates at the pattern length.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en_i) begin
            hist_d = hist_nxt_o[W-2:0];
            fill_d = reach_o ? len_i : fill_inc[LW-1:0];
        end
    end

    // History and fill registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Moore detector for a run-time programmable serial pattern.
// Build option: SEQDET_MATCH_COUNT_EN adds a saturating match counter.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seq_detector_param_if.slave  bus
);

    localparam int LW = $clog2(MAX_LEN + 1);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LW-1:0]      len_q;
    logic               ovl_q;

    logic               load, len_ok, sample;
    logic               match, reach, clr;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN_LIM-1:0] diff;

    assign load   = bus.cfg_load;
    assign len_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LW'(MAX_LEN));
    assign sample = !load && bus.x_valid && (state_q != S_IDLE);

    assign diff  = (MAX_LEN_LIM'(hist_nxt) ^ MAX_LEN_LIM'(pat_q))
                 & len_mask(int'(len_q));
    assign match = reach && (diff == '0);

    // Non-overlap matches restart the window from scratch.
    assign clr = load || (sample && match && !ovl_q);

    seqdet_hist_reg #(
        .W  (MAX_LEN),
        .LW (LW)
    ) u_hist (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (clr),
        .en_i       (sample),
        .x_i        (bus.x),
        .len_i      (len_q),
        .hist_nxt_o (hist_nxt),
        .reach_o    (reach)
    );

    // Latch a configuration only when its length is legal.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= '0;
            len_q <= '0;
            ovl_q <= 1'b0;
        end else if (load && len_ok) begin
            pat_q <= bus.cfg_pattern;
            len_q <= bus.cfg_len;
            ovl_q <= bus.cfg_overlap;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state: load beats sampling; an idle cycle ends a hit.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = len_ok ? S_FILL : S_IDLE;
        end else if (sample) begin
            if (match)      state_d = S_HIT;
            else if (reach) state_d = S_HUNT;
            else            state_d = S_FILL;
        end else if (state_q == S_HIT) begin
            state_d = S_HUNT;
        end
    end

    // Moore outputs from the state register only.
    always_comb begin
        bus.y    = (state_q == S_HIT);
        bus.busy = (state_q != S_IDLE);
    end

`ifdef SEQDET_MATCH_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count each sampled match, saturating; a load restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = '0;
        else if (sample && match && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Match counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign bus.match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param.
// Build option: SEQDET_MATCH_COUNT_EN enables the counter checks.
module tb_seq_detector_param;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2)) bus ();

    seq_detector_param #(
        .MAX_LEN (8),
        .CNT_W   (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_in(input logic b, input logic v);
        @(negedge clk);
        bus.cfg_load = 1'b0;
        bus.x        = b;
        bus.x_valid  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l,
                        input logic o, input logic xv);
        @(negedge clk);
        bus.cfg_load    = 1'b1;
        bus.cfg_pattern = p;
        bus.cfg_len     = l;
        bus.cfg_overlap = o;
        bus.x           = 1'b1;
        bus.x_valid     = xv;
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input logic [15:0] bits, input int n,
                          input logic [15:0] exp_y, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            bit_in(bits[i], 1'b1);
            chk(tag, 32'(bus.y), 32'(exp_y[i]));
        end
    endtask

    initial begin
        n_cmp           = 0;
        n_bad           = 0;
        reset_n         = 1'b0;
        bus.cfg_load    = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        bus.x           = 1'b0;
        bus.x_valid     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", 32'(bus.y), 0);
        chk("rst_busy", 32'(bus.busy), 0);
`ifdef SEQDET_MATCH_COUNT_EN
        chk("rst_cnt", 32'(bus.match_cnt), 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // 1: overlapping 1001 in 1001001
        load(8'b1001, 4'd4, 1'b1, 1'b0);
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_y0", 32'(bus.y), 0);
        stream(16'b1001001, 7, 16'b0001001, "t1_y");

        // 2: non-overlapping, same stream
        load(8'b1001, 4'd4, 1'b0, 1'b0);
        stream(16'b1001001, 7, 16'b0001000, "t2_y");
`ifdef SEQDET_MATCH_COUNT_EN
        chk("t2_cnt", 32'(bus.match_cnt), 1);
`endif

        // 3: gaps between bits 2 and 3
        load(8'b1001, 4'd4, 1'b1, 1'b0);
        stream(16'b10, 2, 16'b00, "t3_pre");
        repeat (3) begin
            bit_in(1'b1, 1'b0);
            chk("t3_gap_y", 32'(bus.y), 0);
            chk("t3_gap_busy", 32'(bus.busy), 1);
        end
        stream(16'b01, 2, 16'b01, "t3_post");
        bit_in(1'b0, 1'b0);
        chk("t3_drop", 32'(bus.y), 0);

        // 4: load wins over a valid bit in the same cycle
        load(8'b11, 4'd2, 1'b1, 1'b1);
        chk("t4_ld_y", 32'(bus.y), 0);
        stream(16'b11, 2, 16'b01, "t4_y");

        // 5: len 1, back-to-back hits, counter saturates
        load(8'b1, 4'd1, 1'b1, 1'b0);
        stream(16'b11111, 5, 16'b11111, "t5_y");
`ifdef SEQDET_MATCH_COUNT_EN
        chk("t5_cnt", 32'(bus.match_cnt), 3);
`endif
        bit_in(1'b1, 1'b0);
        chk("t5_end_y", 32'(bus.y), 0);

        // 6: async reset mid-pattern, then invalid loads
        load(8'b1001, 4'd4, 1'b1, 1'b0);
        stream(16'b10, 2, 16'b00, "t6_pre");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(bus.busy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        stream(16'b1001, 4, 16'b0000, "t6_y");
        chk("t6_busy", 32'(bus.busy), 0);
        load(8'b1001, 4'd0, 1'b1, 1'b0);
        chk("t6_len0", 32'(bus.busy), 0);
        load(8'b1001, 4'd9, 1'b1, 1'b0);
        chk("t6_len9", 32'(bus.busy), 0);
        load(8'hA5, 4'd8, 1'b1, 1'b0);
        chk("t6_len8", 32'(bus.busy), 1);
        load(8'hA5, 4'd0, 1'b1, 1'b0);
        chk("t6_disarm", 32'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
